// File: rtl/tpu_layer_sequencer.sv
// Top-level scheduler for the fully-connected pipeline: runs each layer in turn
// through reset and run, then performs an argmax over the last layer's scores.
module tpu_layer_sequencer #(
    parameter int N_LAYERS   = 2,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 65535,
    parameter int N_CLASSES  = 10
) (
    input  logic                   clk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic [N_LAYERS-1:0]    iLayerDone,
    input  logic [N_LAYERS-1:0]    iLayerOverflow,
    input  logic [N_CLASSES*8-1:0] iScores,
    output logic [N_LAYERS-1:0]    oLayerEna,
    output logic [N_LAYERS-1:0]    oLayerRst_n,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [3:0]             oDigit,
    output logic                   oOverflow,
    output logic                   oTimeout,
    output logic [2:0]             oLayerIdx
);

    localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0]      IDX_LAST = 3'(N_LAYERS - 1);
    localparam logic [3:0]      CLS_LAST = 4'(N_CLASSES - 1);
    localparam bit              WD_ON    = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_RUN,
        S_NEXT,
        S_ARGMAX,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          idx;
    logic [RC_W-1:0]     rst_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic [3:0]          cls;
    logic [7:0]          best_val;
    logic [3:0]          best_idx;
    logic [N_LAYERS-1:0] layer_sel;
    logic                layer_done;
    logic                layer_ovf;
    logic                wd_expired;
    logic                last_layer;
    logic                last_class;
    logic                take;
    logic [7:0]          score_cur;

    assign layer_sel  = N_LAYERS'(1) << idx;
    assign layer_done = |(iLayerDone & layer_sel);
    assign layer_ovf  = |(iLayerOverflow & layer_sel);
    assign wd_expired = WD_ON && (wd_cnt == WD_LAST);
    assign last_layer = (idx == IDX_LAST);
    assign last_class = (cls == CLS_LAST);
    assign oLayerIdx  = idx;

    // Float8 strict greater-than; -0 is folded onto +0 before comparing.
    function automatic logic f8_gt(input logic [7:0] a, input logic [7:0] b);
        logic a_neg;
        logic b_neg;
        a_neg = a[7] && (a[6:0] != 7'd0);
        b_neg = b[7] && (b[6:0] != 7'd0);
        if (a_neg != b_neg)
            return b_neg;
        if (a_neg)
            return a[6:0] < b[6:0];
        return a[6:0] > b[6:0];
    endfunction

    always_comb begin
        score_cur = 8'd0;
        for (int i = 0; i < N_CLASSES; i++)
            if (cls == 4'(i))
                score_cur = iScores[8*i +: 8];
    end

    assign take = (cls == 4'd0) || f8_gt(score_cur, best_val);

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        oLayerEna   = '0;
        oLayerRst_n = '1;
        oBusy       = 1'b1;
        case (state)
            S_IDLE, S_DONE: begin
                oBusy = 1'b0;
                if (iStart)
                    state_nxt = S_LRST;
            end
            S_LRST: begin
                oLayerEna   = layer_sel;
                oLayerRst_n = ~layer_sel;
                if (rst_cnt == RC_LAST)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                oLayerEna = layer_sel;
                if (layer_done)
                    state_nxt = S_NEXT;
                else if (wd_expired)
                    state_nxt = S_FAULT;
            end
            S_NEXT: begin
                // The last layer stays enabled so its scores remain valid for argmax.
                if (last_layer) begin
                    oLayerEna = layer_sel;
                    state_nxt = S_ARGMAX;
                end else begin
                    state_nxt = S_LRST;
                end
            end
            S_ARGMAX: begin
                oLayerEna = layer_sel;
                if (last_class)
                    state_nxt = S_DONE;
            end
            S_FAULT: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            idx       <= '0;
            rst_cnt   <= '0;
            wd_cnt    <= '0;
            cls       <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            oDone     <= 1'b0;
            oDigit    <= '0;
            oOverflow <= 1'b0;
            oTimeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        idx       <= '0;
                        rst_cnt   <= '0;
                        oDone     <= 1'b0;
                        oDigit    <= '0;
                        oOverflow <= 1'b0;
                        oTimeout  <= 1'b0;
                    end
                end
                S_LRST: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    wd_cnt  <= '0;
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (layer_done) begin
                        oOverflow <= oOverflow | layer_ovf;
                    end else if (wd_expired) begin
                        oTimeout <= 1'b1;
                        oDigit   <= 4'hF;
                    end
                end
                S_NEXT: begin
                    cls <= '0;
                    if (!last_layer) begin
                        idx     <= idx + 1'b1;
                        rst_cnt <= '0;
                    end
                end
                S_ARGMAX: begin
                    cls <= cls + 1'b1;
                    if (take) begin
                        best_val <= score_cur;
                        best_idx <= cls;
                    end
                    if (last_class) begin
                        oDigit <= take ? cls : best_idx;
                        oDone  <= 1'b1;
                    end
                end
                S_FAULT: oDone <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Randomised and directed bench for tpu_layer_sequencer: a cycle schedule is
// derived from the layer latencies and compared against the DUT every cycle.
module tb_tpu_layer_sequencer;

    localparam int NL = 2;
    localparam int RC = 2;
    localparam int TO = 20;
    localparam int NC = 10;

    logic            clk = 1'b0;
    logic            iRst;
    logic            iStart;
    logic [NL-1:0]   iLayerDone;
    logic [NL-1:0]   iLayerOverflow;
    logic [NC*8-1:0] iScores;
    logic [NL-1:0]   oLayerEna;
    logic [NL-1:0]   oLayerRst_n;
    logic            oBusy;
    logic            oDone;
    logic [3:0]      oDigit;
    logic            oOverflow;
    logic            oTimeout;
    logic [2:0]      oLayerIdx;

    tpu_layer_sequencer #(
        .N_LAYERS  (NL),
        .RST_CYCLES(RC),
        .TIMEOUT   (TO),
        .N_CLASSES (NC)
    ) dut (
        .clk           (clk),
        .iRst          (iRst),
        .iStart        (iStart),
        .iLayerDone    (iLayerDone),
        .iLayerOverflow(iLayerOverflow),
        .iScores       (iScores),
        .oLayerEna     (oLayerEna),
        .oLayerRst_n   (oLayerRst_n),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oDigit        (oDigit),
        .oOverflow     (oOverflow),
        .oTimeout      (oTimeout),
        .oLayerIdx     (oLayerIdx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Layer stand-ins: layer k raises done in its T-th run cycle (T=0: never)
    // and holds it; disabled layers also see random done noise.
    int            lay_T [NL] = '{0, 0};
    logic [NL-1:0] lay_ov = '0;
    int            lay_cnt [NL] = '{0, 0};
    logic [NL-1:0] noise = '0;
    logic [7:0]    sc [NC];

    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (!oLayerRst_n[k])
                lay_cnt[k] <= 0;
            else if (oLayerEna[k] && lay_cnt[k] < 1000)
                lay_cnt[k] <= lay_cnt[k] + 1;
        end
        noise <= NL'($urandom);
    end

    always_comb begin
        iLayerDone = '0;
        for (int k = 0; k < NL; k++)
            iLayerDone[k] = ((lay_T[k] != 0) && (lay_cnt[k] >= lay_T[k] - 1))
                            | (noise[k] & ~oLayerEna[k]);
        iLayerOverflow = lay_ov;
        iScores = '0;
        for (int i = 0; i < NC; i++)
            iScores[8*i +: 8] = sc[i];
    end

    typedef struct packed {
        logic [NL-1:0] ena;
        logic [NL-1:0] rst_n;
        logic          busy;
        logic          done;
        logic [3:0]    digit;
        logic          ovf;
        logic          tmo;
        logic          chk_st;
        logic [2:0]    idx;
    } exp_t;

    exp_t sched [256];
    int   sched_len;

    function automatic exp_t mk(input logic [NL-1:0] ena, input logic [NL-1:0] rst_n,
                                input logic busy, input logic done, input logic [3:0] digit,
                                input logic ovf, input logic tmo, input logic chk,
                                input logic [2:0] idx);
        exp_t e;
        e.ena = ena; e.rst_n = rst_n; e.busy = busy; e.done = done; e.digit = digit;
        e.ovf = ovf; e.tmo = tmo; e.chk_st = chk; e.idx = idx;
        return e;
    endfunction

    function automatic void push(input exp_t e);
        sched[sched_len] = e;
        sched_len++;
    endfunction

    // Highest Float8 score as a signed value; first index wins a tie.
    function automatic int ref_argmax();
        int best_key = -1000;
        int best = 0;
        for (int i = 0; i < NC; i++) begin
            logic [7:0] s;
            int key;
            s = sc[i];
            key = s[7] ? -int'(s[6:0]) : int'(s[6:0]);
            if (key > best_key) begin
                best_key = key;
                best = i;
            end
        end
        return best;
    endfunction

    // Entry c is the expected output during the c-th cycle after the start edge.
    function automatic void build_sched();
        logic          ovf = 1'b0;
        logic [NL-1:0] one;
        sched_len = 1;
        for (int k = 0; k < NL; k++) begin
            one = NL'(1) << k;
            for (int r = 0; r < RC; r++) push(mk(one, ~one, 1, 0, 0, ovf, 0, 1, 3'(k)));
            if (lay_T[k] >= 1 && lay_T[k] <= TO) begin
                for (int r = 0; r < lay_T[k]; r++) push(mk(one, '1, 1, 0, 0, ovf, 0, 1, 3'(k)));
                ovf = ovf | lay_ov[k];
                push(mk((k == NL-1) ? one : NL'(0), '1, 1, 0, 0, ovf, 0, 1, 3'(k)));
            end else begin
                for (int r = 0; r < TO; r++) push(mk(one, '1, 1, 0, 0, ovf, 0, 1, 3'(k)));
                push(mk('0, '1, 1, 0, 0, ovf, 0, 0, 3'(k)));
                push(mk('0, '1, 0, 1, 4'hF, ovf, 1, 1, 3'(k)));
                return;
            end
        end
        for (int i = 0; i < NC; i++) push(mk(NL'(1) << (NL-1), '1, 1, 0, 0, ovf, 0, 1, 3'(NL-1)));
        push(mk('0, '1, 0, 1, 4'(ref_argmax()), ovf, 0, 1, 3'(NL-1)));
    endfunction

    // Compare process: expectations advance on the clock, outputs are checked at negedge.
    exp_t rst_e;
    exp_t hold_e;
    exp_t cur_e;
    bit   active;
    int   cyc;

    initial begin
        rst_e  = mk('0, '1, 0, 0, 0, 0, 0, 1, 3'd0);
        hold_e = rst_e;
        active = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            if (iRst)        cur_e = rst_e;
            else if (active) cur_e = sched[cyc];
            else             cur_e = hold_e;
            check("ena",   oLayerEna,   cur_e.ena);
            check("rst_n", oLayerRst_n, cur_e.rst_n);
            check("busy",  oBusy,       cur_e.busy);
            check("done",  oDone,       cur_e.done);
            check("ovf",   oOverflow,   cur_e.ovf);
            check("idx",   oLayerIdx,   cur_e.idx);
            if (cur_e.chk_st) begin
                check("digit", oDigit,   cur_e.digit);
                check("tmo",   oTimeout, cur_e.tmo);
            end
            @(posedge clk);
            if (iRst) begin
                active = 0;
                hold_e = rst_e;
            end else if (!active) begin
                if (iStart) begin
                    active = 1;
                    cyc    = 1;
                end
            end else begin
                cyc++;
                if (cyc >= sched_len - 1) begin
                    hold_e = sched[sched_len - 1];
                    active = 0;
                end
            end
        end
    end

    task automatic run_case(input int exp_cyc, input int exp_dig, input int poke);
        int got = 0;
        build_sched();
        @(negedge clk); #2 iStart = 1'b1;
        @(posedge clk); #1 iStart = 1'b0;
        check("busy_start", oBusy, 1);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1 iStart = 1'b0;
            if (oDone) begin
                got = n + 1;
                break;
            end
            if (n == poke) iStart = 1'b1;
        end
        check("done_seen", oDone, 1);
        check("done_cycle", got, sched_len - 1);
        if (exp_cyc > 0) check("done_cycle_lit", got, exp_cyc);
        check("digit_end", oDigit, sched[sched_len - 1].digit);
        if (exp_dig >= 0) check("digit_lit", oDigit, exp_dig);
        check("busy_end", oBusy, 0);
    endtask

    initial begin
        iRst   = 1'b1;
        iStart = 1'b1;
        for (int i = 0; i < NC; i++) sc[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 iStart = 1'b0;
        @(negedge clk); #2 iRst = 1'b0;
        #1;
        check("rst_busy", oBusy, 0);
        check("rst_ena", oLayerEna, 0);
        check("rst_rst_n", oLayerRst_n, 2'b11);
        check("rst_digit", oDigit, 0);
        @(posedge clk); #1 check("idle_busy", oBusy, 0);

        // Normal run: layer latencies 5 and 7, class 3 is the maximum.
        lay_T = '{5, 7}; lay_ov = 2'b00;
        sc = '{8'h10, 8'h44, 8'h20, 8'h45, 8'h00, 8'h85, 8'hC0, 8'h3F, 8'h01, 8'h44};
        run_case(29, 3, -1);
        check("normal_ovf", oOverflow, 0);

        // Overflow from layer 0 only; classes 2 and 7 tie for the maximum.
        lay_T = '{3, 4}; lay_ov = 2'b01;
        sc = '{8'h12, 8'h4F, 8'h50, 8'h00, 8'hD0, 8'h33, 8'h80, 8'h50, 8'h21, 8'h4E};
        run_case(1 + (2+3+1) + (2+4+1) + 10, 2, -1);
        check("tie_ovf", oOverflow, 1);

        // All scores negative: smallest magnitude wins.
        lay_T = '{6, 2}; lay_ov = 2'b00;
        sc = '{8'h90, 8'h85, 8'hFF, 8'h82, 8'hA0, 8'h83, 8'h8F, 8'h84, 8'hC1, 8'h81};
        run_case(0, 9, -1);

        // Watchdog on layer 1; its overflow never counts since it never completes.
        lay_T = '{5, 0}; lay_ov = 2'b10;
        run_case(1 + (2+5+1) + (2+20) + 1, 15, -1);
        check("wd_tmo", oTimeout, 1);
        check("wd_ena", oLayerEna, 0);
        check("wd_ovf", oOverflow, 0);

        // Done already high in the first run cycle, and done on the last watchdog cycle;
        // -0 at class 1 ties with +0 at class 5 as the maximum.
        lay_T = '{1, 20}; lay_ov = 2'b00;
        sc = '{8'h85, 8'h80, 8'h9A, 8'h81, 8'hFF, 8'h00, 8'h82, 8'h80, 8'h90, 8'h88};
        run_case(1 + (2+1+1) + (2+20+1) + 10, 1, -1);
        check("edge_tmo", oTimeout, 0);

        // Reset during layer 0's reset phase, with a start pulse while reset is high.
        lay_T = '{5, 7};
        sc = '{8'h10, 8'h44, 8'h20, 8'h45, 8'h00, 8'h85, 8'hC0, 8'h3F, 8'h01, 8'h44};
        build_sched();
        @(negedge clk); #2 iStart = 1'b1;
        @(posedge clk); #1 iStart = 1'b0;
        @(posedge clk); #2 iRst = 1'b1;
        #1;
        check("mid_rst_ena", oLayerEna, 0);
        check("mid_rst_rst_n", oLayerRst_n, 2'b11);
        check("mid_rst_busy", oBusy, 0);
        check("mid_rst_done", oDone, 0);
        iStart = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 iRst = 1'b0; iStart = 1'b0;
        @(posedge clk); #1 check("post_rst_busy", oBusy, 0);

        // Fresh run with a start pulse injected mid-run.
        run_case(29, 3, 4);

        // Randomised runs, some with narrow score ranges to provoke ties and signed zeros.
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < NL; k++)
                lay_T[k] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            lay_ov = NL'($urandom);
            for (int i = 0; i < NC; i++)
                sc[i] = it[0] ? {1'($urandom_range(0, 1)), 7'($urandom_range(0, 3))}
                              : 8'($urandom);
            run_case(0, -1, it[1] ? int'($urandom_range(2, 12)) : -1);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
